// File: rtl/add_seq_ctrl_pkg.sv
// Shared SUBARRAY_MAC definitions: word width and the sequential adder
// controller state encodings.
package subarray_mac_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq_ctrl_cla16.sv
// CLA_16: 16-bit carry-lookahead adder built from four 4-bit groups with a
// second lookahead level across the groups.
// Ports: a, b (addends), cin (carry in), sum, cout (carry out),
//        Gm/Pm (block generate/propagate for a further lookahead level).
module CLA_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        Gm,
  output logic        Pm
);

  // Carries into bits 0..3 of a 4-bit group.
  function automatic logic [3:0] cin4(input logic [3:0] g, input logic [3:0] p,
                                      input logic ci);
    logic [3:0] c;
    c[0] = ci;
    for (int i = 1; i < 4; i++) c[i] = g[i-1] | (p[i-1] & c[i-1]);
    return c;
  endfunction

  // Group {generate, propagate} of a 4-bit slice.
  function automatic logic [1:0] gp4(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

  logic [15:0] g, p;
  logic [3:0]  gg, gp, gc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    logic [3:0] bc;
    assign {gg[k], gp[k]} = gp4(g[4*k +: 4], p[4*k +: 4]);
    assign bc = cin4(g[4*k +: 4], p[4*k +: 4], gc[k]);
    assign sum[4*k +: 4] = p[4*k +: 4] ^ bc;
  end

  assign gc         = cin4(gg, gp, cin);
  assign {Gm, Pm}   = gp4(gg, gp);
  assign cout       = Gm | (Pm & cin);

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: word-serial multi-word adder/subtractor. One 16-bit CLA is
// reused over NWORD cycles, the carry chained through a register.
// Ports: clk, rst (async, active high);
//        in_valid/in_ready + op_a, op_b, sub : request (sub=1 -> a-b);
//        out_valid/out_ready + sum, cout, ovf : result, held until taken;
//        busy : high while not IDLE.
module add_seq_ctrl
  import subarray_mac_pkg::*;
#(
  parameter int NWORD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*NWORD-1:0] op_a,
  input  logic [WORD_W*NWORD-1:0] op_b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*NWORD-1:0] sum,
  output logic                    cout,
  output logic                    ovf,
  output logic                    busy
);

  localparam int W    = WORD_W * NWORD;
  localparam int IDXW = 3;  // NWORD <= 8

  state_t            state, nxt;
  logic [IDXW-1:0]   idx;
  logic [W-1:0]      ra, rb;   // rb already holds ~b for subtraction
  logic              carry;
  logic [WORD_W-1:0] aw, bw, sw;
  logic              co, gm_unused, pm_unused;
  logic              last;

  assign last = (idx == IDXW'(NWORD - 1));

  // Only combinational path: word select of the captured operands.
  assign aw = ra[WORD_W*idx +: WORD_W];
  assign bw = rb[WORD_W*idx +: WORD_W];

  CLA_16 u_cla (
    .a    (aw),
    .b    (bw),
    .cin  (carry),
    .sum  (sw),
    .cout (co),
    .Gm   (gm_unused),
    .Pm   (pm_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid)  nxt = RUN;
      RUN:     if (last)      nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so every output
  // comes straight off a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      in_ready  <= (nxt == IDLE);
      out_valid <= (nxt == DONE);
      busy      <= (nxt != IDLE);
      case (state)
        IDLE: if (in_valid) begin
          ra    <= op_a;
          rb    <= sub ? ~op_b : op_b;
          idx   <= '0;
          carry <= sub;  // +1 completes the two's complement of b
        end
        RUN: begin
          sum[WORD_W*idx +: WORD_W] <= sw;
          carry <= co;
          idx   <= idx + 1'b1;
          if (last) begin
            cout <= co;
            ovf  <= (ra[W-1] == rb[W-1]) && (sw[WORD_W-1] != ra[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 SHALL have parameter NWORD, default 4, giving the operand length in 16-bit words; the legal range is 1..8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: an operation request is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the controller can accept a request.
REQ-006 SHALL have port op_a, input, 16*NWORD bits: the first operand.
REQ-007 SHALL have port op_b, input, 16*NWORD bits: the second operand.
REQ-008 SHALL have port sub, input, 1 bit: 0 selects a+b; 1 selects a-b.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is present.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port sum, output, 16*NWORD bits: the result word.
REQ-012 SHALL have port cout, output, 1 bit: carry out of the MSB word.
REQ-013 SHALL have port ovf, output, 1 bit: two's-complement overflow.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement an FSM with exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE SHALL drive in_ready=1; in_ready SHALL be 0 in every other state.
REQ-017 In IDLE, in_valid=1 SHALL, on that edge:
- capture op_a and op_b;
- capture op_b inverted when sub=1;
- set the word index to 0;
- set the carry register to sub;
- enter RUN.
REQ-018 Each RUN cycle SHALL:
- add captured word[idx] of a and b' plus the carry register through the shared 16-bit adder;
- write the result into sum[16*idx +: 16];
- load the carry register with the adder carry-out;
- increment idx.
REQ-019 On the RUN cycle with idx==NWORD-1, the FSM SHALL:
- latch cout from the adder carry-out;
- latch ovf = (a_msb==b'_msb) && (sum_msb!=a_msb);
- enter DONE.
REQ-020 Latency SHALL be NWORD cycles: out_valid rises exactly NWORD edges after the accepting edge (NWORD=1 gives one RUN cycle).
REQ-021 DONE SHALL drive out_valid=1, and sum, cout and ovf SHALL stay stable until out_ready=1.
REQ-022 DONE with out_ready=1 SHALL enter IDLE on that edge.
REQ-023 A request arriving in the same cycle as the DONE handshake SHALL NOT be accepted in that cycle; it is accepted in IDLE one cycle later.
REQ-024 The minimum issue interval SHALL be NWORD+2 cycles; no operations overlap.
REQ-025 in_valid and operand changes during RUN or DONE SHALL be ignored.
REQ-026 Word arithmetic SHALL be modulo 2^16 per word and modulo 2^(16*NWORD) overall; carry SHALL propagate only through the registered carry.
REQ-027 For subtraction, cout=1 SHALL mean no borrow (a>=b unsigned).

Reset
REQ-028 rst=1 SHALL asynchronously force:
- the FSM to IDLE;
- idx, the carry register, sum, cout, ovf, out_valid and busy to 0;
- in_ready to 1.
REQ-029 Reset during RUN or DONE SHALL discard the operation without a partial result; the first request after reset release SHALL complete correctly.

Structure
REQ-030 SHALL place WORD_W=16 and the IDLE, RUN and DONE state encodings in the shared SUBARRAY_MAC package.
REQ-031 SHALL contain exactly one instance of the existing CLA_16 adder as its only sub-module, with Gm and Pm left unused.
REQ-032 All outputs SHALL be driven from registers; the only combinational path SHALL be the operand mux into the adder.

Verification (NWORD=4)
REQ-033 SHALL cover: a=0x0000_0000_0000_FFFF, b=1, sub=0 -> sum=0x0000_0000_0001_0000, cout=0, ovf=0, out_valid 4 cycles after accept.
REQ-034 SHALL cover: a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> sum=0, cout=1, ovf=0; and a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
REQ-035 SHALL cover: sub=1, a=5, b=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; and sub=1, a=b=0x1234_5678_9ABC_DEF0 -> sum=0, cout=1.
REQ-036 SHALL cover: out_ready held 0 for 10 cycles in DONE with in_valid pulsing -> out_valid, sum, cout and ovf stable, in_ready=0, no extra results.
REQ-037 SHALL cover: rst pulsed at RUN idx=2 -> all outputs at reset values immediately, in_ready=1; the next request a=1, b=2 -> sum=3.
REQ-038 SHALL cover: back-to-back requests with out_ready=1 -> accepts exactly 6 cycles apart, and results match a software model for 1000 random operand and sub values.
